// File: rtl/pcie_app_pkg.sv
// Shared types and helpers for the PCIe application TX completion path:
// completion status codes, TLP fmt/type encodings, the queued request
// record and the 3DW completion header builder.
package pcie_app_pkg;

  typedef enum logic [2:0] {
    CPL_SC = 3'b000,
    CPL_UR = 3'b001,
    CPL_CA = 3'b100
  } cpl_status_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_HDR,
    ST_TAIL
  } cpl_state_e;

  localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
  localparam logic [1:0] FMT_3DW_DATA   = 2'b10;
  localparam logic [4:0] TYPE_CPL       = 5'b01010;

  // One pending completion: everything needed to build the header later.
  typedef struct packed {
    logic [15:0] id;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [9:0]  len;
    logic [31:0] addr;
    cpl_status_e status;
  } cpl_req_t;

  // Returns {DW2, DW1, DW0}. Only SC carries a payload (CplD, length 1);
  // UR/CA are header-only Cpl. Byte count is len*4 truncated to 12 bits,
  // so len=0 (1024 DW) reports 0.
  function automatic logic [95:0] cpl_hdr(input cpl_req_t req,
                                          input logic [15:0] completer_id);
    logic        has_data;
    logic [31:0] dw0;
    logic [31:0] dw1;
    logic [31:0] dw2;
    has_data = (req.status == CPL_SC);
    dw0 = {1'b0, (has_data ? FMT_3DW_DATA : FMT_3DW_NODATA), TYPE_CPL,
           1'b0, req.tc, 4'b0000, 1'b0, 1'b0, req.attr, 2'b00,
           (has_data ? 10'd1 : 10'd0)};
    dw1 = {completer_id, req.status, 1'b0, req.len, 2'b00};
    dw2 = {req.id, req.tag, 1'b0, req.addr[6:0]};
    return {dw2, dw1, dw0};
  endfunction

endpackage

// File: rtl/cpl_req_fifo.sv
// Synchronous FIFO of pending completion requests with occupancy output.
// The parent only pushes when not full and only pops when not empty.
import pcie_app_pkg::*;

module cpl_req_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  cpl_req_t               push_data,
  input  logic                   pop,
  output cpl_req_t               head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  cpl_req_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Entry storage write.
  // NOTE: the storage array is deliberately not reset; the pointers and count
  // alone decide which entries are valid, and a reset here would stop the
  // array from mapping onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy update; pointers wrap naturally modulo DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/pcie_cpl_tx.sv
// Completion generator for the application TX path. Queues non-posted
// requests from the RX classifier, reads a register for supported 1-DW MRd,
// and emits a two-beat 3DW Cpl/CplD on a 64-bit Avalon-ST style interface.
// Optional build macro: PCIE_CPL_RD_TIMEOUT_EN (bounded register-read wait
// that turns a missing rd_ack into a CA completion).
import pcie_app_pkg::*;

module pcie_cpl_tx #(
  parameter int DEPTH      = 4,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            completer_id,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_fmt,
  input  logic [4:0]             req_type,
  input  logic                   req_ur,
  input  logic                   req_np,
  input  logic [15:0]            req_id,
  input  logic [7:0]             req_tag,
  input  logic [2:0]             req_tc,
  input  logic [1:0]             req_attr,
  input  logic [9:0]             req_len,
  input  logic [31:0]            req_addr,
  output logic                   rd_req,
  output logic [31:0]            rd_addr,
  input  logic                   rd_ack,
  input  logic [31:0]            rd_data,
  output logic [63:0]            tx_data,
  output logic                   tx_sop,
  output logic                   tx_eop,
  output logic                   tx_empty,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pcie_cpl_tx: DEPTH must be a power of two >= 2");
  end
  if (RD_TIMEOUT < 1) begin : g_bad_rd_timeout
    $error("pcie_cpl_tx: RD_TIMEOUT must be >= 1");
  end

  cpl_req_t    in_req;
  cpl_req_t    head;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [95:0] head_hdr;
  cpl_state_e  state;
  logic [31:0] rd_data_q;
  logic [31:0] dw2_q;
  logic        sc_q;

  // fmt/type are already folded into the classifier verdicts.
  logic unused_req_bits;
  assign unused_req_bits = ^{req_fmt, req_type};

`ifdef PCIE_CPL_RD_TIMEOUT_EN
  localparam int TW = ($clog2(RD_TIMEOUT + 1) > 8) ? $clog2(RD_TIMEOUT + 1) : 8;
  logic [TW-1:0] tmo_cnt;
  cpl_req_t      head_ca;
  logic [95:0]   ca_hdr;

  // Header used when the read gives up: same request, reported as CA.
  always_comb begin
    head_ca        = head;
    head_ca.status = CPL_CA;
    ca_hdr         = cpl_hdr(head_ca, completer_id);
  end
`endif

  // Classify and pack the incoming request; the status is fixed at enqueue.
  always_comb begin
    in_req.id   = req_id;
    in_req.tag  = req_tag;
    in_req.tc   = req_tc;
    in_req.attr = req_attr;
    in_req.len  = req_len;
    in_req.addr = req_addr;
    if (req_ur)              in_req.status = CPL_UR;
    else if (req_len != 10'd1) in_req.status = CPL_CA;
    else                     in_req.status = CPL_SC;
  end

  // No bypass: a full FIFO refuses even if the head pops this cycle.
  assign req_ready = (pending < DEPTH_C);
  assign push      = req_valid && req_ready && req_np;
  assign pop       = (state == ST_TAIL) && tx_ready;
  assign head_hdr  = cpl_hdr(head, completer_id);

  cpl_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(in_req),
    .pop      (pop),
    .head     (head),
    .empty    (fifo_empty),
    .count    (pending)
  );

  // Completion FSM with registered read and TX outputs; the head entry stays
  // put until TAIL is accepted, so the header can be rebuilt from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      rd_data_q <= '0;
      dw2_q     <= '0;
      sc_q      <= 1'b0;
      tx_data   <= '0;
      tx_sop    <= 1'b0;
      tx_eop    <= 1'b0;
      tx_empty  <= 1'b0;
      tx_valid  <= 1'b0;
`ifdef PCIE_CPL_RD_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (head.status == CPL_SC) begin
              rd_req  <= 1'b1;
              rd_addr <= head.addr;
              state   <= ST_RD_WAIT;
`ifdef PCIE_CPL_RD_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end else begin
              sc_q     <= 1'b0;
              dw2_q    <= head_hdr[95:64];
              tx_data  <= head_hdr[63:0];
              tx_sop   <= 1'b1;
              tx_valid <= 1'b1;
              state    <= ST_HDR;
            end
          end
        end
        ST_RD_WAIT: begin
          if (rd_ack) begin
            rd_req    <= 1'b0;
            rd_data_q <= rd_data;
            sc_q      <= 1'b1;
            dw2_q     <= head_hdr[95:64];
            tx_data   <= head_hdr[63:0];
            tx_sop    <= 1'b1;
            tx_valid  <= 1'b1;
            state     <= ST_HDR;
          end
`ifdef PCIE_CPL_RD_TIMEOUT_EN
          else if (tmo_cnt == TW'(RD_TIMEOUT - 1)) begin
            rd_req   <= 1'b0;
            sc_q     <= 1'b0;
            dw2_q    <= ca_hdr[95:64];
            tx_data  <= ca_hdr[63:0];
            tx_sop   <= 1'b1;
            tx_valid <= 1'b1;
            state    <= ST_HDR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        ST_HDR: begin
          if (tx_ready) begin
            tx_sop   <= 1'b0;
            tx_eop   <= 1'b1;
            tx_empty <= !sc_q;
            tx_data  <= sc_q ? {rd_data_q, dw2_q} : {32'h0, dw2_q};
            state    <= ST_TAIL;
          end
        end
        ST_TAIL: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_eop   <= 1'b0;
            tx_empty <= 1'b0;
            tx_data  <= '0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_cpl_tx.sv
// Self-checking bench for pcie_cpl_tx: expected TX beats are pushed to a
// scoreboard queue when each request is driven and compared as beats are
// accepted; a register responder supplies read data with a chosen latency.
// Define PCIE_CPL_RD_TIMEOUT_EN for both RTL and bench to cover the timeout.
module tb_pcie_cpl_tx;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] completer_id;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_fmt;
  logic [4:0]  req_type;
  logic        req_ur;
  logic        req_np;
  logic [15:0] req_id;
  logic [7:0]  req_tag;
  logic [2:0]  req_tc;
  logic [1:0]  req_attr;
  logic [9:0]  req_len;
  logic [31:0] req_addr;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic [63:0] tx_data;
  logic        tx_sop;
  logic        tx_eop;
  logic        tx_empty;
  logic        tx_valid;
  logic        tx_ready;
  logic [2:0]  pending;

  int n_checks = 0;
  int n_errors = 0;
  int n_rd     = 0;
  int n_beats  = 0;
  int rd_lat   = 3;
  int rd_wait  = 0;
  int rd_hi    = 0;
  int last_hi  = 0;
  bit ack_en   = 1'b1;

  logic [66:0] expq[$];   // {data, sop, eop, empty}
  logic [31:0] rdq[$];
  logic [31:0] addrq[$];

  pcie_cpl_tx #(.DEPTH(DEPTH), .RD_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .completer_id(completer_id),
    .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
    .req_type(req_type), .req_ur(req_ur), .req_np(req_np), .req_id(req_id),
    .req_tag(req_tag), .req_tc(req_tc), .req_attr(req_attr),
    .req_len(req_len), .req_addr(req_addr), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .tx_empty(tx_empty), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference header model built from field positions of a 3DW completion.
  function automatic logic [95:0] model_hdr(input logic [2:0] st,
      input logic [9:0] len, input logic [15:0] id, input logic [7:0] tag,
      input logic [2:0] tc, input logic [1:0] attr, input logic [31:0] addr);
    logic [31:0] dw0;
    logic [31:0] dw1;
    logic [31:0] dw2;
    logic [11:0] bc;
    bc  = {len, 2'b00};
    dw0 = 32'h0A00_0000 | ((st == 3'b000) ? 32'h4000_0001 : 32'h0)
        | (32'(tc) << 20) | (32'(attr) << 12);
    dw1 = (32'(completer_id) << 16) | (32'(st) << 13) | 32'(bc);
    dw2 = (32'(id) << 16) | (32'(tag) << 8) | 32'(addr[6:0]);
    return {dw2, dw1, dw0};
  endfunction

  task automatic drive_req(input logic np, input logic ur,
      input logic [9:0] len, input logic [31:0] addr, input logic [7:0] tag,
      input logic [15:0] id, input logic [2:0] tc, input logic [1:0] attr);
    int n = 0;
    req_valid = 1'b1;
    req_np    = np;
    req_ur    = ur;
    req_len   = len;
    req_addr  = addr;
    req_tag   = tag;
    req_id    = id;
    req_tc    = tc;
    req_attr  = attr;
    req_fmt   = np ? 2'b00 : 2'b10;
    req_type  = 5'b00000;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("req_ready_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Pushes the expected completion (and read) for a non-posted request.
  task automatic send_req(input logic ur, input logic [9:0] len,
      input logic [31:0] addr, input logic [7:0] tag, input logic [15:0] id,
      input logic [2:0] tc, input logic [1:0] attr, input logic [31:0] rdat);
    logic [2:0]  st;
    logic [95:0] h;
    st = ur ? 3'b001 : ((len != 10'd1) ? 3'b100 : 3'b000);
    if (st == 3'b000) begin
      if (ack_en) begin
        rdq.push_back(rdat);
        addrq.push_back(addr);
      end else begin
        st = 3'b100;
      end
    end
    h = model_hdr(st, len, id, tag, tc, attr, addr);
    expq.push_back({h[63:0], 3'b100});
    if (st == 3'b000) expq.push_back({rdat, h[95:64], 3'b010});
    else              expq.push_back({32'h0, h[95:64], 3'b011});
    drive_req(1'b1, ur, len, addr, tag, id, tc, attr);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((expq.size() != 0 || tx_valid || pending != 0) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_reached", (n < 1000), 1);
  endtask

  task automatic wait_tx_valid();
    int n = 0;
    while (!tx_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("tx_valid_seen", tx_valid, 1);
  endtask

  // Register responder: acks rd_req after rd_lat idle cycles.
  initial begin
    rd_ack  = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_ack  = 1'b0;
        rd_wait = 0;
        rd_hi   = 0;
      end else begin
        if (rd_req) rd_hi++;
        else if (rd_hi != 0) begin
          last_hi = rd_hi;
          rd_hi   = 0;
        end
        if (rd_ack) rd_ack = 1'b0;
        else if (rd_req && ack_en) begin
          if (rd_wait >= rd_lat) begin
            rd_wait = 0;
            if (rdq.size() == 0) check("rd_unexpected", 1, 0);
            else begin
              rd_data = rdq.pop_front();
              check("rd_addr", rd_addr, addrq.pop_front());
            end
            rd_ack = 1'b1;
            n_rd++;
          end else begin
            rd_wait++;
          end
        end
      end
    end
  end

  // TX monitor: compares accepted beats and checks stability under stall.
  initial begin
    logic [66:0] cur;
    logic [66:0] hold_beat;
    bit          hold_v;
    hold_v    = 1'b0;
    hold_beat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else if (tx_valid) begin
        cur = {tx_data, tx_sop, tx_eop, tx_empty};
        if (hold_v) check("tx_stable", cur, hold_beat);
        if (tx_ready) begin
          if (expq.size() == 0) check("tx_unexpected", cur, 0);
          else check("tx_beat", cur, expq.pop_front());
          hold_v = 1'b0;
          n_beats++;
        end else begin
          hold_v    = 1'b1;
          hold_beat = cur;
        end
      end else begin
        if (hold_v) check("tx_valid_dropped", 0, 1);
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    int rd0;
    int b0;
    logic [2:0] p0;
    rst_n = 1'b0; completer_id = 16'h0200; req_valid = 1'b0;
    req_fmt = '0; req_type = '0; req_ur = 1'b0; req_np = 1'b0; req_id = '0;
    req_tag = '0; req_tc = '0; req_attr = '0; req_len = '0; req_addr = '0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {tx_valid, tx_sop, tx_eop, tx_empty, rd_req}, 0);
    check("rst_data", {tx_data, rd_addr}, 0);
    check("rst_pending", pending, 0);
    check("rst_req_ready", req_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: supported MRd, read latency 3, literal expected beats.
    tx_ready = 1'b1;
    expq.push_back({64'h0200_0004_4A00_0001, 3'b100});
    expq.push_back({64'hDEAD_BEEF_0100_0540, 3'b010});
    rdq.push_back(32'hDEAD_BEEF);
    addrq.push_back(32'h40);
    rd0 = n_rd;
    drive_req(1'b1, 1'b0, 10'd1, 32'h40, 8'h05, 16'h0100, 3'd0, 2'd0);
    wait_idle();
    check("t1_one_read", n_rd - rd0, 1);

    // 2: unsupported request -> UR Cpl, no read.
    rd0 = n_rd;
    send_req(1'b1, 10'd1, 32'h44, 8'h11, 16'h0100, 3'd0, 2'd0, 32'h0);
    wait_idle();
    check("t2_no_read", n_rd, rd0);

    // 3: len=4 and len=0 -> CA Cpl (byte count 16 and 0), no read.
    send_req(1'b0, 10'd4, 32'h48, 8'h12, 16'h0101, 3'd2, 2'd1, 32'h0);
    send_req(1'b0, 10'd0, 32'h4C, 8'h13, 16'h0102, 3'd0, 2'd0, 32'h0);
    wait_idle();
    check("t3_no_read", n_rd, rd0);

    // 4: fill the FIFO while the sink stalls.
    tx_ready = 1'b0;
    rd_lat   = 1;
    rd0      = n_rd;
    send_req(1'b0, 10'd1, 32'h100, 8'h20, 16'h0300, 3'd0, 2'd0, 32'h1111_1111);
    send_req(1'b1, 10'd1, 32'h104, 8'h21, 16'h0301, 3'd1, 2'd0, 32'h0);
    send_req(1'b0, 10'd2, 32'h108, 8'h22, 16'h0302, 3'd0, 2'd3, 32'h0);
    send_req(1'b0, 10'd1, 32'h7C,  8'h23, 16'h0303, 3'd5, 2'd2, 32'h2222_2222);
    check("t4_req_ready_full", req_ready, 0);
    check("t4_pending_full", pending, 4);
    wait_tx_valid();
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("t4_one_read", n_rd - rd0, 1);
    check("t4_pending_held", pending, 4);
    tx_ready = 1'b1;
    wait_idle();
    check("t4_all_reads", n_rd - rd0, 2);

    // 5: posted write is accepted and dropped.
    p0 = pending;
    b0 = n_beats;
    drive_req(1'b0, 1'b0, 10'd1, 32'h200, 8'h30, 16'h0400, 3'd0, 2'd0);
    check("t5_pending", pending, p0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("t5_no_tlp", n_beats, b0);

    // Back-to-back burst: pushes overlap pops, pointers wrap.
    for (int i = 0; i < 9; i++) begin
      send_req(1'($urandom_range(0, 1)), 10'($urandom_range(0, 3)),
               32'($urandom_range(0, 255)) << 2, 8'($urandom_range(0, 255)),
               16'h0500 + 16'(i), 3'($urandom_range(0, 7)),
               2'($urandom_range(0, 3)), $urandom());
    end
    wait_idle();

`ifdef PCIE_CPL_RD_TIMEOUT_EN
    // 6: read never acknowledged -> rd_req for 8 cycles, then CA Cpl.
    ack_en = 1'b0;
    rd0    = n_rd;
    send_req(1'b0, 10'd1, 32'h88, 8'h33, 16'h0600, 3'd0, 2'd0, 32'h0);
    wait_idle();
    check("t6_rd_req_cycles", last_hi, 8);
    check("t6_no_ack", n_rd, rd0);
    ack_en = 1'b1;
`endif

    // Reset in the middle of TAIL drops the packet and the queue.
    tx_ready = 1'b0;
    send_req(1'b1, 10'd1, 32'h300, 8'h40, 16'h0700, 3'd0, 2'd0, 32'h0);
    send_req(1'b1, 10'd1, 32'h304, 8'h41, 16'h0701, 3'd0, 2'd0, 32'h0);
    wait_tx_valid();
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    check("rst_mid_tail_eop", tx_eop, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {tx_valid, tx_sop, tx_eop, tx_empty, rd_req}, 0);
    check("rst_mid_data", tx_data, 0);
    check("rst_mid_pending", pending, 0);
    expq.delete();
    rdq.delete();
    addrq.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b1;
    send_req(1'b0, 10'd1, 32'h3C, 8'h42, 16'h0702, 3'd0, 2'd0, 32'hCAFE_0001);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pcie_cpl_tx.md
Name: pcie_cpl_tx

Overview:
- Completion generator for the PCIe application TX path; it is the responder to the RX request classifier.
- Accepts decoded non-posted requests and queues them. For a supported 1-DW MRd it reads a 32-bit register; it then emits a 3DW Cpl/CplD TLP on a 64-bit Avalon-ST-style TX interface.
- Unsupported or malformed requests get header-only completions: UR or CA.

Parameters:
- DEPTH, 4, pending-request FIFO entries (power of 2, >=2)
- RD_TIMEOUT, 255, register-read wait limit in clk cycles (used only with the optional feature)

Ports:
- clk  in  1  application clock
- rst_n  in  1  asynchronous active-low reset
- completer_id  in  16  bus/dev/func from config space
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid&&req_ready
- req_fmt  in  2  TLP fmt
- req_type  in  5  TLP type
- req_ur  in  1  classifier verdict: unsupported
- req_np  in  1  classifier verdict: non-posted
- req_id  in  16  requester ID
- req_tag  in  8  tag
- req_tc  in  3  traffic class
- req_attr  in  2  attributes
- req_len  in  10  length in DW (0 = 1024)
- req_addr  in  32  DW-aligned address
- rd_req  out  1  register read request, level
- rd_addr  out  32  register address
- rd_ack  in  1  read data valid
- rd_data  in  32  read data
- tx_data  out  64  beat data
- tx_sop  out  1  first beat
- tx_eop  out  1  last beat
- tx_empty  out  1  upper DW of beat invalid
- tx_valid  out  1  beat valid
- tx_ready  in  1  sink accepts beat
- pending  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: all outputs 0; FIFO emptied; FSM = IDLE. Reset mid-TLP aborts the packet and drops every queued request.
- req_ready = (pending < DEPTH), combinational. There is no bypass on full, even when a pop occurs in the same cycle.
- Accepted requests with req_np=0 are dropped: no enqueue, no completion.
- Status per entry:
  - UR (3'b001) if req_ur.
  - Else CA (3'b100) if req_len != 1.
  - Else SC (3'b000).
- FSM IDLE:
  - FIFO empty: stay in IDLE.
  - Head entry SC: assert rd_req with rd_addr = head addr, go to RD_WAIT.
  - Otherwise: go to HDR.
- FSM RD_WAIT:
  - Hold rd_req until the cycle rd_ack=1.
  - In that cycle, capture rd_data, drop rd_req on the next edge, go to HDR.
  - Exactly one read per request, regardless of TX backpressure.
- FSM HDR:
  - tx_valid=1, tx_sop=1, tx_data = {DW1,DW0}.
  - On tx_ready, go to TAIL.
- FSM TAIL:
  - tx_valid=1, tx_eop=1.
  - SC: tx_data = {data,DW2}, tx_empty=0.
  - UR/CA: tx_data = {32'h0,DW2}, tx_empty=1.
  - On tx_ready, pop FIFO, go to IDLE.
- Once tx_valid is asserted, tx_valid and all tx_* fields stay stable until accepted.
- Minimum spacing between TLPs: SC 1 + read latency + 2 cycles; UR/CA 3 cycles.
- DW0:
  - fmt = 2'b10 (CplD) for SC, 2'b00 (Cpl) otherwise.
  - type = 5'b01010.
  - TC and attr copied from the request.
  - length = 1 for CplD, 0 for Cpl.
  - TD = EP = 0.
- DW1: {completer_id, status, BCM=0, byte_count}.
  - byte_count = {req_len,2'b00}[11:0]; SC therefore yields 4, and len=0 yields 0.
- DW2: {req_id, req_tag, 1'b0, req_addr[6:0]}.
- FIFO push and pop in the same cycle: occupancy unchanged; the pointers wrap modulo DEPTH.

Optional Feature:
- Macro: PCIE_CPL_RD_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter runs in RD_WAIT.
  - After RD_TIMEOUT cycles without rd_ack: drop rd_req, set status to CA, go to HDR (Cpl, header only).
  - An rd_ack arriving after the timeout is ignored.
- Undefined: RD_WAIT waits indefinitely; no counter logic is present.

Decomposition:
- Package pcie_app_pkg holds:
  - cpl_status_e enum (SC/UR/CA).
  - TLP fmt/type localparams (FMT_3DW_NODATA, FMT_3DW_DATA, TYPE_CPL).
  - Packed struct cpl_req_t (id, tag, tc, attr, len, addr, status).
  - Function cpl_hdr(), which builds {DW2,DW1,DW0}.
- Sub-module cpl_req_fifo: synchronous FIFO of cpl_req_t, DEPTH-parameterised, with count output.

Test Plan:
1. MRd len=1, addr=32'h40, tag=8'h05, req_id=16'h0100, completer_id=16'h0200; rd_ack after 3 cycles with rd_data=32'hDEADBEEF -> two beats.
   - Beat 0: fmt=10, length=1, status=000, byte_count=4.
   - Beat 1: {32'hDEADBEEF, 16'h0100, 8'h05, 1'b0, 7'h40}, tx_empty=0.
2. req_ur=1, tag=8'h11 -> no rd_req; Cpl with fmt=00, length=0, status=001; tx_empty=1 on the eop beat.
3. MRd len=4 -> CA Cpl, byte_count=16, no rd_req.
4. Fill DEPTH=4 with tx_ready=0 -> req_ready=0 and pending=4.
   - Hold tx_ready low 5 cycles: tx_data stable, exactly one rd_req handshake.
   - Release: four TLPs emitted in FIFO order.
5. MWr with req_np=0 -> accepted, no TLP emitted, pending unchanged.
6. With PCIE_CPL_RD_TIMEOUT_EN and RD_TIMEOUT=8, rd_ack never arrives -> rd_req drops after 8 cycles, CA Cpl emitted.
   - Also: assert rst_n=0 mid-TAIL -> all outputs 0 and pending=0 immediately.
